// File: rtl/lfsr_spawn_scheduler_pkg.sv
// Shared definitions for the spawn scheduler: mode codes, FSM states,
// spawn kind width, default cooldowns and a saturating counter helper.
package lfsr_spawn_scheduler_pkg;

    localparam int KIND_W = 2;
    localparam int MODE_W = 2;
    localparam int CNT_W  = 8;
    localparam int CD_W   = 8;

    localparam logic [MODE_W-1:0] MODE_EASY    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_NORMAL  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_EXTREME = 2'b10;
    localparam logic [MODE_W-1:0] MODE_OFF     = 2'b11;

    localparam int CD_EASY_DEF    = 8;
    localparam int CD_NORMAL_DEF  = 4;
    localparam int CD_EXTREME_DEF = 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STEP     = 3'd1,
        S_SAMPLE   = 3'd2,
        S_OFFER    = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    // Statistics counters stick at their maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lfsr_spawn_scheduler_lane_rr_pick.sv
// Rotating first-free-lane picker: starting at the candidate lane, walks
// upward modulo LANES and returns the first lane that is not busy.
module lane_rr_pick #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic [LANE_W-1:0] cand,
    input  logic [LANES-1:0]  lane_busy,
    output logic [LANE_W-1:0] lane,
    output logic              found
);

    logic [LANE_W-1:0] idx;

    // Scan from the farthest offset down so the closest free lane wins last.
    always_comb begin
        lane  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = (LANES == 1) ? '0 : cand + LANE_W'(k);
            if (!lane_busy[idx]) begin
                lane  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_spawn_scheduler.sv
// Spawn scheduler: steps the pseudo-random generator once per game tick,
// samples the difficulty trigger, offers a spawn to a free lane over a
// valid/ready handshake and then waits out a per-mode cooldown.
module lfsr_spawn_scheduler
    import lfsr_spawn_scheduler_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int CD_EASY    = CD_EASY_DEF,
    parameter int CD_NORMAL  = CD_NORMAL_DEF,
    parameter int CD_EXTREME = CD_EXTREME_DEF,
    parameter int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              tick,
    input  logic [1:0]        mode,
    input  logic [4:0]        prn,
    input  logic              easy_t,
    input  logic              normal_t,
    input  logic              extreme_t,
    output logic              lfsr_step,
    input  logic [LANES-1:0]  lane_busy,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [LANE_W-1:0] spawn_lane,
    output logic [1:0]        spawn_kind,
    output logic [7:0]        spawn_count,
    output logic [7:0]        miss_count,
    output logic              cooling
);

    state_t            state;
    state_t            state_next;
    logic [CD_W-1:0]   cd_latched;
    logic [CD_W-1:0]   cd_cnt;
    logic              trig;
    logic              hit;
    logic [LANE_W-1:0] cand;
    logic [LANE_W-1:0] pick_lane;
    logic              pick_found;
    logic              unused_prn;

    function automatic logic [CD_W-1:0] cd_for_mode(input logic [1:0] m);
        case (m)
            MODE_EASY:    return CD_W'(CD_EASY);
            MODE_NORMAL:  return CD_W'(CD_NORMAL);
            MODE_EXTREME: return CD_W'(CD_EXTREME);
            default:      return '0;
        endcase
    endfunction

    // Only the lane and kind fields of prn matter; the rest is folded away.
    assign unused_prn = ^prn;
    assign cand       = (LANES == 1) ? '0 : prn[LANE_W-1:0];
    assign hit        = trig & pick_found;

    lane_rr_pick #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_pick (
        .cand      (cand),
        .lane_busy (lane_busy),
        .lane      (pick_lane),
        .found     (pick_found)
    );

    // Select the generator trigger that belongs to the current difficulty.
    always_comb begin
        trig = 1'b0;
        case (mode)
            MODE_EASY:    trig = easy_t;
            MODE_NORMAL:  trig = normal_t;
            MODE_EXTREME: trig = extreme_t;
            default:      trig = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; an offer is never withdrawn until it is accepted.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (tick && run) state_next = S_STEP;
            S_STEP:     state_next = S_SAMPLE;
            S_SAMPLE:   state_next = hit ? S_OFFER : S_IDLE;
            S_OFFER:    if (spawn_ready) state_next = (cd_latched == '0) ? S_IDLE : S_COOLDOWN;
            S_COOLDOWN: if (tick && cd_cnt == CD_W'(1)) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state.
    always_comb begin
        lfsr_step   = 1'b0;
        spawn_valid = 1'b0;
        cooling     = 1'b0;
        case (state)
            S_STEP:     lfsr_step   = 1'b1;
            S_OFFER:    spawn_valid = 1'b1;
            S_COOLDOWN: cooling     = 1'b1;
            default:    ;
        endcase
    end

    // Offer payload, cooldown bookkeeping and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_lane  <= '0;
            spawn_kind  <= '0;
            spawn_count <= '0;
            miss_count  <= '0;
            cd_latched  <= '0;
            cd_cnt      <= '0;
        end else begin
            case (state)
                S_SAMPLE: begin
                    if (hit) begin
                        spawn_lane <= pick_lane;
                        spawn_kind <= prn[4:3];
                        cd_latched <= cd_for_mode(mode);
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                end
                S_OFFER: begin
                    if (spawn_ready) begin
                        spawn_count <= sat_inc(spawn_count);
                        cd_cnt      <= cd_latched;
                    end
                end
                S_COOLDOWN: begin
                    if (tick) cd_cnt <= cd_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_spawn_scheduler.sv
// Bench for lfsr_spawn_scheduler: a small 5-bit generator model drives prn
// and the triggers, a behavioural model predicts every cycle's outputs and
// the spawn offers, and a monitor compares the DUT against those predictions.
module tb_lfsr_spawn_scheduler;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              tick = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [4:0]        prn;
    logic              easy_t, normal_t, extreme_t;
    logic              lfsr_step;
    logic [LANES-1:0]  lane_busy = '0;
    logic              spawn_valid;
    logic              spawn_ready = 1'b0;
    logic [LANE_W-1:0] spawn_lane;
    logic [1:0]        spawn_kind;
    logic [7:0]        spawn_count, miss_count;
    logic              cooling;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [1:0]        kind;
    } spawn_t;

    spawn_t exp_q[$];

    // Reference model state: which phase of a spawn attempt is pending.
    bit m_step_due, m_sample_due, m_offer;
    int m_cool_left, m_cd_hold, m_spawns, m_misses;

    // Expected outputs for the current cycle.
    bit e_step, e_valid, e_cooling;
    int e_spawns, e_misses;

    always #5 clk = ~clk;

    lfsr_spawn_scheduler #(.LANES(LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .tick        (tick),
        .mode        (mode),
        .prn         (prn),
        .easy_t      (easy_t),
        .normal_t    (normal_t),
        .extreme_t   (extreme_t),
        .lfsr_step   (lfsr_step),
        .lane_busy   (lane_busy),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_lane  (spawn_lane),
        .spawn_kind  (spawn_kind),
        .spawn_count (spawn_count),
        .miss_count  (miss_count),
        .cooling     (cooling)
    );

    function automatic logic [4:0] gen_next(input logic [4:0] p);
        logic [4:0] s;
        s = p >> 1;
        if (p[0]) s = s ^ 5'b10100;
        return s;
    endfunction

    function automatic bit easy_fn(input logic [4:0] p);
        return p < 5'd8;
    endfunction

    function automatic bit normal_fn(input logic [4:0] p);
        return (p % 4) != 0;
    endfunction

    function automatic bit extreme_fn(input logic [4:0] p);
        return p != 5'd0;
    endfunction

    // Generator stand-in, sharing the scheduler's reset and clock enable.
    always @(posedge clk) begin
        if (rst)            prn <= 5'b11111;
        else if (lfsr_step) prn <= gen_next(prn);
    end

    assign easy_t    = easy_fn(prn);
    assign normal_t  = normal_fn(prn);
    assign extreme_t = extreme_fn(prn);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the behavioural model across the upcoming clock edge.
    task automatic model_step(input bit r, input bit rn, input bit tk, input logic [1:0] md,
                              input logic [LANES-1:0] busy, input bit rdy);
        bit                trig;
        bit                found;
        logic [LANE_W-1:0] l;
        logic [LANE_W-1:0] lane_sel;
        if (r) begin
            m_step_due = 0; m_sample_due = 0; m_offer = 0;
            m_cool_left = 0; m_cd_hold = 0; m_spawns = 0; m_misses = 0;
            exp_q.delete();
        end else if (m_step_due) begin
            m_step_due   = 0;
            m_sample_due = 1;
        end else if (m_sample_due) begin
            m_sample_due = 0;
            case (md)
                2'd0:    trig = easy_fn(prn);
                2'd1:    trig = normal_fn(prn);
                2'd2:    trig = extreme_fn(prn);
                default: trig = 0;
            endcase
            found    = 0;
            lane_sel = '0;
            for (int k = 0; k < LANES; k++) begin
                l = LANE_W'((int'(prn) + k) % LANES);
                if (!found && !busy[l]) begin
                    found    = 1;
                    lane_sel = l;
                end
            end
            if (trig && found) begin
                m_offer   = 1;
                m_cd_hold = (md == 2'd0) ? 8 : (md == 2'd1) ? 4 : 1;
                exp_q.push_back('{lane: lane_sel, kind: 2'(int'(prn) / 8)});
            end else begin
                m_misses = (m_misses < 255) ? m_misses + 1 : 255;
            end
        end else if (m_offer) begin
            if (rdy) begin
                m_offer     = 0;
                m_spawns    = (m_spawns < 255) ? m_spawns + 1 : 255;
                m_cool_left = m_cd_hold;
            end
        end else if (m_cool_left > 0) begin
            if (tk) m_cool_left--;
        end else if (rn && tk) begin
            m_step_due = 1;
        end
    endtask

    // Drive one cycle's inputs just after the edge and predict the next edge.
    task automatic applyStimulus(input bit r, input bit rn, input bit tk, input logic [1:0] md,
                                 input logic [LANES-1:0] busy, input bit rdy);
        @(posedge clk);
        #1;
        e_step    = m_step_due;
        e_valid   = m_offer;
        e_cooling = (m_cool_left > 0);
        e_spawns  = m_spawns;
        e_misses  = m_misses;
        rst         = r;
        run         = rn;
        tick        = tk;
        mode        = md;
        lane_busy   = busy;
        spawn_ready = rdy;
        model_step(r, rn, tk, md, busy, rdy);
    endtask

    task automatic cyc(input bit tk, input logic [1:0] md, input logic [LANES-1:0] busy, input bit rdy);
        applyStimulus(1'b0, 1'b1, tk, md, busy, rdy);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, '0, 1'b1);
    endtask

    // Monitor: per-cycle outputs against the model, offers against the queue.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("lfsr_step",   32'(lfsr_step),   32'(e_step));
            checkOutput("spawn_valid", 32'(spawn_valid), 32'(e_valid));
            checkOutput("cooling",     32'(cooling),     32'(e_cooling));
            checkOutput("spawn_count", 32'(spawn_count), e_spawns);
            checkOutput("miss_count",  32'(miss_count),  e_misses);
            if (spawn_valid === 1'b1 && !rst) begin
                if (exp_q.size() == 0) begin
                    checkOutput("offer_expected", 32'(spawn_valid), 32'd0);
                end else begin
                    checkOutput("offer_lane", 32'(spawn_lane), 32'(exp_q[0].lane));
                    checkOutput("offer_kind", 32'(spawn_kind), 32'(exp_q[0].kind));
                    if (spawn_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, '0, 1'b1);
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_lane", 32'(spawn_lane), 32'd0);
        checkOutput("reset_kind", 32'(spawn_kind), 32'd0);

        // Normal mode, one tick: step, sample 11011, offer lane 3 kind 3, cooldown 4.
        cyc(1, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s1_step", 32'(lfsr_step), 32'd1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s1_prn", 32'(prn), 32'd27);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s1_valid", 32'(spawn_valid), 32'd1);
        checkOutput("s1_lane", 32'(spawn_lane), 32'd3);
        checkOutput("s1_kind", 32'(spawn_kind), 32'd3);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s1_count", 32'(spawn_count), 32'd1);
        checkOutput("s1_cooling", 32'(cooling), 32'd1);
        repeat (4) cyc(1, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s1_cool_done", 32'(cooling), 32'd0);

        // Easy mode: 11011 does not trigger, one miss.
        do_reset();
        cyc(1, 2'b00, '0, 1);
        repeat (3) cyc(0, 2'b00, '0, 1);
        @(negedge clk);
        checkOutput("s2_miss", 32'(miss_count), 32'd1);
        checkOutput("s2_valid", 32'(spawn_valid), 32'd0);

        // Lane wrap from candidate 3 to lane 0.
        do_reset();
        cyc(1, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1);
        cyc(0, 2'b01, 4'b1000, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s3_wrap_lane", 32'(spawn_lane), 32'd0);

        // All lanes busy: miss.
        do_reset();
        cyc(1, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1);
        cyc(0, 2'b01, 4'b1111, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s3_busy_miss", 32'(miss_count), 32'd1);
        checkOutput("s3_busy_valid", 32'(spawn_valid), 32'd0);

        // Offer held with ready low while inputs and ticks churn.
        do_reset();
        cyc(1, 2'b01, '0, 0);
        repeat (3) cyc(0, 2'b01, '0, 0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), (i % 4) == 0, 2'($urandom_range(0, 3)),
                          4'($urandom), 1'b0);
            @(negedge clk);
            checkOutput("s4_hold_valid", 32'(spawn_valid), 32'd1);
            checkOutput("s4_hold_lane", 32'(spawn_lane), 32'd3);
            checkOutput("s4_hold_kind", 32'(spawn_kind), 32'd3);
        end
        cyc(0, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s4_count", 32'(spawn_count), 32'd1);

        // Reset mid-offer, then restart from 11111 and reset mid-cooldown.
        do_reset();
        cyc(1, 2'b01, '0, 0);
        repeat (3) cyc(0, 2'b01, '0, 0);
        do_reset(); @(negedge clk);
        checkOutput("s6_rst_valid", 32'(spawn_valid), 32'd0);
        checkOutput("s6_rst_lane", 32'(spawn_lane), 32'd0);
        checkOutput("s6_rst_kind", 32'(spawn_kind), 32'd0);
        cyc(1, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1); @(negedge clk);
        checkOutput("s6_restart_prn", 32'(prn), 32'd27);
        cyc(0, 2'b01, '0, 1);
        cyc(0, 2'b01, '0, 1);
        do_reset(); @(negedge clk);
        checkOutput("s6_rst_cooling", 32'(cooling), 32'd0);
        checkOutput("s6_rst_count", 32'(spawn_count), 32'd0);

        // Extreme mode saturation, then mode off counts only misses.
        do_reset();
        repeat (1600) cyc(1, 2'b10, '0, 1);
        @(negedge clk);
        checkOutput("s5_spawn_sat", 32'(spawn_count), 32'd255);
        repeat (900) cyc(1, 2'b11, 4'($urandom), 1);
        @(negedge clk);
        checkOutput("s5_miss_sat", 32'(miss_count), 32'd255);
        checkOutput("s5_spawn_hold", 32'(spawn_count), 32'd255);

        // Randomised traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 3,
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
                          1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lfsr_spawn_scheduler.md
Name: lfsr_spawn_scheduler

Overview:
- Controller for the 5-bit pseudo-random generator used by the game logic.
- Steps the generator once per game tick and picks the difficulty trigger (easy/normal/extreme).
- On a hit, arbitrates a free lane and offers a spawn request to the lane logic over a valid/ready handshake.
- Enforces a per-difficulty cooldown and keeps spawn and miss statistics.

Parameters:
- LANES, 4, number of spawn lanes; power of two, 1..8; LANE_W = max(1, log2(LANES)).
- CD_EASY, 8, cooldown in ticks after an accepted spawn in easy mode.
- CD_NORMAL, 4, cooldown in ticks, normal mode.
- CD_EXTREME, 1, cooldown in ticks, extreme mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = scheduling enabled
- tick  in  1  one-cycle game tick pulse
- mode  in  2  00 easy, 01 normal, 10 extreme, 11 off
- prn  in  5  generator output
- easy_t  in  1  generator easy trigger
- normal_t  in  1  generator normal trigger
- extreme_t  in  1  generator extreme trigger
- lfsr_step  out  1  one-cycle advance pulse to the generator (its clock enable)
- lane_busy  in  LANES  1 = lane cannot accept a spawn
- spawn_valid  out  1  spawn offer pending
- spawn_ready  in  1  lane logic accepts the offer
- spawn_lane  out  LANE_W  target lane
- spawn_kind  out  2  object kind
- spawn_count  out  8  accepted spawns, saturating at 255
- miss_count  out  8  sampled ticks with no spawn, saturating at 255
- cooling  out  1  1 while in COOLDOWN

Behaviour:
- Reset: synchronous, on rising clk while rst=1.
  - State goes to IDLE.
  - All outputs go to 0: lfsr_step, spawn_valid, spawn_lane, spawn_kind, spawn_count, miss_count, cooling.
  - The generator instance shares rst, so prn is 5'b11111 after reset.
- FSM states: IDLE, STEP, SAMPLE, OFFER, COOLDOWN.
- IDLE:
  - If tick=1 and run=1, go to STEP next cycle.
  - Ticks with run=0 are ignored.
- STEP:
  - lfsr_step=1 for exactly this cycle; go to SAMPLE.
  - The generator updates at the end of STEP, so prn is valid in SAMPLE.
- SAMPLE:
  - Trigger selected by mode: 00 uses easy_t, 01 normal_t, 10 extreme_t, 11 forces 0.
  - Candidate lane c = prn[LANE_W-1:0] (c = 0 when LANES=1).
  - Lane choice: first lane with lane_busy=0, searching c, c+1, ... modulo LANES, evaluated in this cycle.
  - Trigger=1 and a free lane exists: latch spawn_lane = chosen lane, spawn_kind = prn[4:3], latch the cooldown for the current mode, go to OFFER.
  - Otherwise: miss_count += 1 (saturating), go to IDLE.
- OFFER:
  - spawn_valid=1; spawn_lane and spawn_kind are held stable.
  - Valid is never withdrawn, independent of run, tick, mode or lane_busy changes.
  - Handshake is spawn_valid & spawn_ready on a rising edge. It takes effect in the same cycle: spawn_count += 1 (saturating), spawn_valid=0 next cycle.
  - After handshake: latched cooldown 0 goes to IDLE; otherwise load the counter and go to COOLDOWN.
  - Ticks arriving during OFFER are dropped and not counted.
- COOLDOWN:
  - cooling=1; the counter decrements on each tick, regardless of run.
  - A tick with counter=1 goes to IDLE; that tick does not start a new step.
- Latency: tick in cycle T (IDLE) gives lfsr_step in T+1, SAMPLE in T+2, spawn_valid from T+3. With ready high, handshake completes in T+3.
- Mode change: takes effect at the next SAMPLE. The cooldown is fixed at the value latched in SAMPLE.
- Tick coinciding with rst: ignored.
- Counters saturate; they do not wrap.

Decomposition:
- Shared game package holds:
  - mode encodings MODE_EASY/NORMAL/EXTREME/OFF
  - FSM state encoding
  - spawn kind width (2)
  - default cooldown constants
- One natural sub-module: lane_rr_pick, a combinational rotate-from-candidate first-free-lane picker (inputs c and lane_busy; outputs lane and found).

Test Plan:
- Reset, mode=01, lane_busy=0, ready=1, one tick -> lfsr_step pulses once; prn=5'b11011; spawn_valid at tick+3 with spawn_lane=3, spawn_kind=3; spawn_count=1; then cooling=1 for 4 ticks.
- Same as above with mode=00 -> easy_t=0, no spawn_valid, miss_count=1, back in IDLE at tick+3.
- mode=01, lane_busy=4'b1000 on the first step -> spawn_lane=0 (wrap); lane_busy=4'b1111 -> no offer, miss_count=1.
- OFFER with ready held 0 for 10 cycles plus 3 ticks -> spawn_valid, lane and kind stable throughout; no lfsr_step; ready=1 completes it; spawn_count=1.
- Continuous ticks, mode=10, ready=1, 300 spawns -> spawn_count saturates at 255; mode=11 -> only misses counted.
- rst asserted mid-OFFER and mid-COOLDOWN -> next cycle all outputs 0, state IDLE, next tick restarts from prn=5'b11111.
